// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit Von Neumann CPU: opcodes, control-FSM states
// and the datapath mux/ALU select codes used by both control and datapath.
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_LI  = 4'h4;
    localparam logic [3:0] OP_LD  = 4'h5;
    localparam logic [3:0] OP_ST  = 4'h6;
    localparam logic [3:0] OP_MOV = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JN  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_IMM    = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] ADDR_PC   = 2'b00;
    localparam logic [1:0] ADDR_IMM  = 2'b01;
    localparam logic [1:0] ADDR_SREG = 2'b10;

    localparam logic [1:0] REG_ALU  = 2'b00;
    localparam logic [1:0] REG_IMM  = 2'b01;
    localparam logic [1:0] REG_DIN  = 2'b10;
    localparam logic [1:0] REG_SREG = 2'b11;

    // Instructions that carry an immediate byte after the opcode byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        case (op)
            OP_LI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JN: is_two_byte = 1'b1;
            default:                                   is_two_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control.sv
// Multi-cycle control FSM: FETCH -> DECODE -> [IMM] -> EXEC, plus HALT.
// All strobes are decoded combinationally from state and the IR opcode.
module cpu_control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irvalue,
    input  logic       zero,
    input  logic       negative,
    output logic       irload,
    output logic       imload,
    output logic       pcsel,
    output logic       pcload,
    output logic       readwrite,
    output logic       dwrite,
    output logic [1:0] addrsel,
    output logic [1:0] regsel,
    output logic [1:0] aluop,
    output logic [1:0] dregsel,
    output logic [1:0] sregsel,
    output logic       halted,
    output logic [7:0] instr_count
);

    logic [2:0] state, state_nx;
    logic       zf, nf;
    logic [7:0] cnt;
    logic [3:0] op;

    assign op = irvalue[7:4];

    always_comb begin
        state_nx = ST_FETCH;
        case (state)
            ST_FETCH:  state_nx = ST_DECODE;
            ST_DECODE: begin
                if (op == OP_HLT)        state_nx = ST_HALT;
                else if (is_two_byte(op)) state_nx = ST_IMM;
                else                      state_nx = ST_EXEC;
            end
            ST_IMM:    state_nx = ST_EXEC;
            ST_EXEC:   state_nx = ST_FETCH;
            ST_HALT:   state_nx = ST_HALT;
            default:   state_nx = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            zf    <= 1'b0;
            nf    <= 1'b0;
            cnt   <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == ST_EXEC) begin
                cnt <= cnt + 8'h01;
                if (op <= OP_OR) begin
                    zf <= zero;
                    nf <= negative;
                end
            end
        end
    end

    // Reset overrides every output, including the register-index passthroughs.
    always_comb begin
        irload      = 1'b0;
        imload      = 1'b0;
        pcsel       = 1'b0;
        pcload      = 1'b0;
        readwrite   = 1'b0;
        dwrite      = 1'b0;
        addrsel     = ADDR_PC;
        regsel      = REG_ALU;
        aluop       = ALU_ADD;
        dregsel     = 2'b00;
        sregsel     = 2'b00;
        halted      = 1'b0;
        instr_count = 8'h00;
        if (rst_n) begin
            dregsel     = irvalue[3:2];
            sregsel     = irvalue[1:0];
            instr_count = cnt;
            case (state)
                ST_FETCH: begin
                    irload = 1'b1;
                    pcload = 1'b1;
                end
                ST_IMM: begin
                    imload = 1'b1;
                    pcload = 1'b1;
                end
                ST_EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            aluop  = op[1:0];
                            regsel = REG_ALU;
                            dwrite = 1'b1;
                        end
                        OP_LI: begin
                            regsel = REG_IMM;
                            dwrite = 1'b1;
                        end
                        OP_LD: begin
                            addrsel = ADDR_IMM;
                            regsel  = REG_DIN;
                            dwrite  = 1'b1;
                        end
                        OP_ST: begin
                            addrsel   = ADDR_IMM;
                            readwrite = 1'b1;
                        end
                        OP_MOV: begin
                            regsel = REG_SREG;
                            dwrite = 1'b1;
                        end
                        OP_JMP: begin
                            pcsel  = 1'b1;
                            pcload = 1'b1;
                        end
                        OP_JZ: begin
                            pcsel  = 1'b1;
                            pcload = zf;
                        end
                        OP_JN: begin
                            pcsel  = 1'b1;
                            pcload = nf;
                        end
                        default: ;
                    endcase
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Checks cpu_control against an instruction-level model: each instruction is
// expanded into its phase list and the expected strobes for every cycle.
module tb_cpu_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irvalue = 8'h00;
    logic       zero = 1'b0, negative = 1'b0;
    logic       irload, imload, pcsel, pcload, readwrite, dwrite, halted;
    logic [1:0] addrsel, regsel, aluop, dregsel, sregsel;
    logic [7:0] instr_count;

    cpu_control dut (
        .clk(clk), .rst_n(rst_n), .irvalue(irvalue), .zero(zero), .negative(negative),
        .irload(irload), .imload(imload), .pcsel(pcsel), .pcload(pcload),
        .readwrite(readwrite), .dwrite(dwrite), .addrsel(addrsel), .regsel(regsel),
        .aluop(aluop), .dregsel(dregsel), .sregsel(sregsel), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam int PF = 0, PD = 1, PI = 2, PE = 3, PH = 4;

    int         n_chk = 0, n_fail = 0;
    bit         chk_en = 0;
    int         cur_ph = PF;
    logic [24:0] dut_v, exp_v;
    bit         mzf = 0, mnf = 0;
    int         mcnt = 0;

    assign dut_v = {irload, imload, pcload, dwrite, pcsel, readwrite, addrsel, regsel,
                    aluop, dregsel, sregsel, halted, instr_count};

    function automatic bit two_byte(input logic [3:0] op);
        return (op >= 4'h4 && op <= 4'hA && op != 4'h7);
    endfunction

    // Expected outputs for one cycle of a given instruction phase.
    function automatic logic [24:0] model(input bit r, input int ph, input logic [7:0] ir);
        logic irl = 0, iml = 0, pcl = 0, dw = 0, ps = 0, rw = 0, hl = 0;
        logic [1:0] as = 0, rs = 0, ao = 0;
        int op = int'(ir[7:4]);
        if (!r) return 25'd0;
        case (ph)
            PF: begin irl = 1; pcl = 1; end
            PI: begin iml = 1; pcl = 1; end
            PE: begin
                if (op < 4) begin ao = 2'(op); dw = 1; end
                else case (op)
                    4:  begin rs = 2'd1; dw = 1; end
                    5:  begin as = 2'd1; rs = 2'd2; dw = 1; end
                    6:  begin as = 2'd1; rw = 1; end
                    7:  begin rs = 2'd3; dw = 1; end
                    8:  begin ps = 1; pcl = 1; end
                    9:  begin ps = 1; pcl = mzf; end
                    10: begin ps = 1; pcl = mnf; end
                    default: ;
                endcase
            end
            PH: hl = 1;
            default: ;
        endcase
        return {irl, iml, pcl, dw, ps, rw, as, rs, ao, ir[3:2], ir[1:0], hl, 8'(mcnt)};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (dut_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t phase=%0d ir=%h got=%h want=%h",
                         $time, cur_ph, irvalue, dut_v, exp_v);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // z: 0/1 forces the zero flag, anything else randomises it.
    task automatic begin_cyc(input bit r, input int ph, input logic [7:0] ir, input int z);
        rst_n    = r;
        irvalue  = ir;
        zero     = (z == 0 || z == 1) ? z[0] : 1'($urandom);
        negative = 1'($urandom);
        cur_ph   = ph;
        exp_v    = model(r, ph, ir);
        chk_en   = 1;
        #2;
    endtask

    task automatic end_cyc();
        @(posedge clk);
        if (!rst_n) begin
            mzf = 0; mnf = 0; mcnt = 0;
        end else if (cur_ph == PE) begin
            mcnt = (mcnt + 1) % 256;
            if (irvalue[7:4] < 4'h4) begin mzf = zero; mnf = negative; end
        end
        #1;
    endtask

    // Runs one non-HLT instruction; abort_at names a phase index taken with rst_n low.
    task automatic run_instr(input logic [7:0] ir, input int abort_at, input int z);
        int phs[4];
        int n;
        phs[0] = PF; phs[1] = PD;
        if (two_byte(ir[7:4])) begin phs[2] = PI; phs[3] = PE; n = 4; end
        else begin phs[2] = PE; n = 3; end
        for (int i = 0; i < n; i++) begin
            begin_cyc(i != abort_at, phs[i], (i == 0) ? irvalue : ir, z);
            end_cyc();
            if (i == abort_at) return;
        end
    endtask

    initial begin
        // Reset held for three cycles: everything low.
        for (int i = 0; i < 3; i++) begin
            begin_cyc(0, PF, 8'h4C, 2);
            check("reset_outputs_zero", 32'(dut_v), 32'd0);
            end_cyc();
        end

        // ADD R1,R2 with zero=1
        begin_cyc(1, PF, irvalue, 2);
        check("fetch_irload", 32'(irload), 1);
        check("fetch_pcload", 32'(pcload), 1);
        check("fetch_addrsel", 32'(addrsel), 0);
        end_cyc();
        begin_cyc(1, PD, 8'h06, 2); end_cyc();
        begin_cyc(1, PE, 8'h06, 1);
        check("add_aluop", 32'(aluop), 0);
        check("add_dwrite", 32'(dwrite), 1);
        check("add_dregsel", 32'(dregsel), 1);
        check("add_sregsel", 32'(sregsel), 2);
        end_cyc();
        begin_cyc(1, PF, irvalue, 2);
        check("add_count", 32'(instr_count), 1);
        check("add_next_fetch", 32'(irload), 1);
        end_cyc();

        // LI R3 (resumes after the FETCH above)
        begin_cyc(1, PD, 8'h4C, 2); end_cyc();
        begin_cyc(1, PI, 8'h4C, 2);
        check("li_imload", 32'(imload), 1);
        check("li_imm_pcload", 32'(pcload), 1);
        end_cyc();
        begin_cyc(1, PE, 8'h4C, 2);
        check("li_regsel", 32'(regsel), 1);
        check("li_dwrite", 32'(dwrite), 1);
        check("li_dregsel", 32'(dregsel), 3);
        end_cyc();

        // JZ after SUB with zero=1, then after ADD with zero=0
        run_instr(8'h10, -1, 1);
        run_instr(8'h90, 2, 2);   // abort in IMM clears count and flags
        run_instr(8'h10, -1, 1);
        begin_cyc(1, PF, irvalue, 2); end_cyc();
        begin_cyc(1, PD, 8'h90, 2); end_cyc();
        begin_cyc(1, PI, 8'h90, 2); end_cyc();
        begin_cyc(1, PE, 8'h90, 2);
        check("jz_taken_pcsel", 32'(pcsel), 1);
        check("jz_taken_pcload", 32'(pcload), 1);
        end_cyc();
        run_instr(8'h00, -1, 0);
        begin_cyc(1, PF, irvalue, 2); end_cyc();
        begin_cyc(1, PD, 8'h90, 2); end_cyc();
        begin_cyc(1, PI, 8'h90, 2); end_cyc();
        begin_cyc(1, PE, 8'h90, 2);
        check("jz_not_taken_pcload", 32'(pcload), 0);
        end_cyc();

        // ST R2,[imm]
        begin_cyc(1, PF, irvalue, 2); end_cyc();
        begin_cyc(1, PD, 8'h62, 2); end_cyc();
        begin_cyc(1, PI, 8'h62, 2); end_cyc();
        begin_cyc(1, PE, 8'h62, 2);
        check("st_addrsel", 32'(addrsel), 1);
        check("st_readwrite", 32'(readwrite), 1);
        check("st_dwrite", 32'(dwrite), 0);
        check("st_sregsel", 32'(sregsel), 2);
        end_cyc();

        // HLT: count so far is SUB, JZ, ADD, JZ, ST after the abort = 5
        begin_cyc(1, PF, irvalue, 2); end_cyc();
        begin_cyc(1, PD, 8'hF0, 2); end_cyc();
        for (int i = 0; i < 10; i++) begin
            begin_cyc(1, PH, 8'hF0, 2);
            if (i == 0) check("hlt_halted", 32'(halted), 1);
            if (i == 9) check("hlt_count_held", 32'(instr_count), 5);
            end_cyc();
        end
        begin_cyc(0, PF, 8'hF0, 2); end_cyc();

        // Reset pulse during IMM
        run_instr(8'h40, -1, 2);
        run_instr(8'h5D, 2, 2);
        begin_cyc(1, PF, irvalue, 2);
        check("abort_fetch_irload", 32'(irload), 1);
        check("abort_count_zero", 32'(instr_count), 0);
        end_cyc();
        begin_cyc(1, PD, 8'hB0, 2); end_cyc();
        begin_cyc(1, PE, 8'hB0, 2); end_cyc();

        // Randomised instruction stream, including aborts, halts and counter wrap
        for (int k = 0; k < 600; k++) begin
            logic [7:0] ir;
            ir = 8'($urandom);
            if (ir[7:4] == 4'hF) begin
                begin_cyc(1, PF, irvalue, 2); end_cyc();
                begin_cyc(1, PD, ir, 2); end_cyc();
                repeat ($urandom_range(1, 4)) begin begin_cyc(1, PH, ir, 2); end_cyc(); end
                begin_cyc(0, PF, ir, 2); end_cyc();
            end else if ($urandom_range(0, 19) == 0) begin
                run_instr(ir, $urandom_range(0, two_byte(ir[7:4]) ? 3 : 2), 2);
            end else begin
                run_instr(ir, -1, 2);
            end
        end

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
